alu_top: RTL and testbench

- Synchronous 8-bit unsigned ALU.
- Two operands and a 3-bit opcode are sampled every clock; the selected result is registered on the output.
- Operations: add, subtract, multiply, divide, modulo, AND, OR, XOR.
- Leaf datapath block, driven directly by a controller or bench with no handshake.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_divider.sv | 39 +++
 rtl/alu_top.sv | 71 +++++++
 tb/tb_alu_top.sv | 131 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit unsigned ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } opcode_t;

    // Quotient reported when the divisor is zero.
    localparam logic [ALU_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/alu_divider.sv
// Combinational restoring divider, fully unrolled so one operation completes per clock.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quot;

    // One shift/trial-subtract/restore stage per dividend bit, MSB first.
    always_comb begin
        rem  = '0;
        diff = '0;
        quot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            rem  = {rem[WIDTH-1:0], dividend_i[i]};
            diff = rem - {1'b0, divisor_i};
            if (!diff[WIDTH]) begin
                rem     = diff;
                quot[i] = 1'b1;
            end else begin
                quot[i] = 1'b0;
            end
        end
    end

    assign quotient_o    = quot;
    assign remainder_o   = rem[WIDTH-1:0];
    assign div_by_zero_o = (divisor_i == '0);

endmodule

// File: rtl/alu_top.sv
// 8-bit unsigned ALU: opcode mux feeding registered result and error flag, 1-cycle latency.
module alu_top
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o
);

    logic [WIDTH-1:0] result_d, result_q;
    logic             err_d, err_q;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .dividend_i    (data0_i),
        .divisor_i     (data1_i),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero)
    );

    // Select the result for the current opcode; all arithmetic wraps to WIDTH bits.
    always_comb begin
        result_d = '0;
        err_d    = 1'b0;
        case (opcode_t'(ctrl_i))
            OP_ADD: result_d = data0_i + data1_i;
            OP_SUB: result_d = data0_i - data1_i;
            OP_MUL: result_d = data0_i * data1_i;
            OP_DIV: begin
                result_d = div_by_zero ? DIV0_QUOTIENT[WIDTH-1:0] : quotient;
                err_d    = div_by_zero;
            end
            OP_MOD: begin
                // Divide by zero returns the dividend unchanged.
                result_d = div_by_zero ? data0_i : remainder;
                err_d    = div_by_zero;
            end
            OP_AND: result_d = data0_i & data1_i;
            OP_OR:  result_d = data0_i | data1_i;
            OP_XOR: result_d = data0_i ^ data1_i;
            default: begin
                result_d = '0;
                err_d    = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears any in-flight result immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign result_o = result_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_alu_top.sv
// Directed self-checking bench for alu_top with hand-computed expected values.
module tb_alu_top;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [2:0] ctrl_i;
    logic [7:0] data0_i;
    logic [7:0] data1_i;
    logic [7:0] result_o;
    logic       err_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0] c;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       e;
    } vec_t;

    vec_t tbl[10];

    always #5 clk_i = ~clk_i;

    alu_top dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .ctrl_i   (ctrl_i),
        .data0_i  (data0_i),
        .data1_i  (data1_i),
        .result_o (result_o),
        .err_o    (err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        ctrl_i  = c;
        data0_i = a;
        data1_i = b;
    endtask

    // Apply one operation, then sample just after the capturing edge.
    task automatic run_op(input string tag, input logic [2:0] c, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic ee);
        drive(c, a, b);
        @(posedge clk_i);
        #1;
        check_eq({tag, ".res"}, {24'd0, result_o}, {24'd0, er});
        check_eq({tag, ".err"}, {31'd0, err_o}, {31'd0, ee});
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(3'b000, 8'd100, 8'd55);
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_hold.res", {24'd0, result_o}, 32'd0);
        check_eq("rst_hold.err", {31'd0, err_o}, 32'd0);

        // First capture is on the first edge with rst_ni high: 100+55.
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("rst_release.res", {24'd0, result_o}, 32'd155);
        check_eq("rst_release.err", {31'd0, err_o}, 32'd0);

        run_op("add_wrap", 3'b000, 8'd200, 8'd100, 8'd44,  1'b0);
        run_op("sub_wrap", 3'b001, 8'd3,   8'd5,   8'd254, 1'b0);
        run_op("mul",      3'b010, 8'd12,  8'd10,  8'd120, 1'b0);
        run_op("mul_wrap", 3'b010, 8'd20,  8'd20,  8'd144, 1'b0);
        run_op("div",      3'b011, 8'd100, 8'd7,   8'd14,  1'b0);
        run_op("mod",      3'b100, 8'd100, 8'd7,   8'd2,   1'b0);
        run_op("div_by1",  3'b011, 8'd255, 8'd1,   8'd255, 1'b0);
        run_op("mod_small",3'b100, 8'd5,   8'd9,   8'd5,   1'b0);
        run_op("div0",     3'b011, 8'd42,  8'd0,   8'd255, 1'b1);
        run_op("mod0",     3'b100, 8'd42,  8'd0,   8'd42,  1'b1);
        run_op("after0",   3'b000, 8'd1,   8'd1,   8'd2,   1'b0);
        run_op("and",      3'b101, 8'hF0,  8'h3C,  8'h30,  1'b0);
        run_op("or",       3'b110, 8'hF0,  8'h3C,  8'hFC,  1'b0);
        run_op("xor",      3'b111, 8'hF0,  8'h3C,  8'hCC,  1'b0);

        // Mid-stream reset: outputs clear before any further clock edge.
        run_op("pre_rst",  3'b011, 8'd9,   8'd0,   8'd255, 1'b1);
        drive(3'b000, 8'd7, 8'd7);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("async_rst.res", {24'd0, result_o}, 32'd0);
        check_eq("async_rst.err", {31'd0, err_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check_eq("rst_edge.res", {24'd0, result_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Back-to-back: a different opcode every cycle.
        tbl[0] = '{c: 3'b000, a: 8'd250, b: 8'd10,  r: 8'd4,   e: 1'b0};
        tbl[1] = '{c: 3'b001, a: 8'd0,   b: 8'd1,   r: 8'd255, e: 1'b0};
        tbl[2] = '{c: 3'b010, a: 8'd255, b: 8'd255, r: 8'd1,   e: 1'b0};
        tbl[3] = '{c: 3'b011, a: 8'd200, b: 8'd13,  r: 8'd15,  e: 1'b0};
        tbl[4] = '{c: 3'b100, a: 8'd200, b: 8'd13,  r: 8'd5,   e: 1'b0};
        tbl[5] = '{c: 3'b011, a: 8'd7,   b: 8'd0,   r: 8'd255, e: 1'b1};
        tbl[6] = '{c: 3'b101, a: 8'hAA,  b: 8'h0F,  r: 8'h0A,  e: 1'b0};
        tbl[7] = '{c: 3'b100, a: 8'd9,   b: 8'd0,   r: 8'd9,   e: 1'b1};
        tbl[8] = '{c: 3'b110, a: 8'hA0,  b: 8'h05,  r: 8'hA5,  e: 1'b0};
        tbl[9] = '{c: 3'b111, a: 8'hFF,  b: 8'h0F,  r: 8'hF0,  e: 1'b0};
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("b2b%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].e);
        end

        // Extra divider points exercising the top quotient bits.
        run_op("div_big",  3'b011, 8'd255, 8'd16,  8'd15,  1'b0);
        run_op("mod_big",  3'b100, 8'd255, 8'd16,  8'd15,  1'b0);
        run_op("div_same", 3'b011, 8'd128, 8'd128, 8'd1,   1'b0);
        run_op("div_half", 3'b011, 8'd254, 8'd2,   8'd127, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
